// File: rtl/wb_trace_fifo.sv
// Commit-trace FIFO: tags every architectural register write with a sequence number.
// One-cycle fall-through to out_*; when full with no pop the record is dropped, flagged and counted.
module wb_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [31:0]   debug_wb_pc,
    input  logic [3:0]    debug_wb_rf_we,
    input  logic [4:0]    debug_wb_rf_wnum,
    input  logic [31:0]   debug_wb_rf_wdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic [3:0]    out_we,
    output logic [4:0]    out_wnum,
    output logic [31:0]   out_wdata,
    output logic [15:0]   out_seq,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [15:0]   drop_count,
    input  logic          clear_ovf
);

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  we;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic [15:0] seq;
    } rec_t;

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    rec_t          mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   seq_q, seq_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    logic capture, pop, push, drop, full;
    rec_t wr_rec, head;

    always_comb begin
        capture = (debug_wb_rf_we != 4'b0) && (debug_wb_rf_wnum != 5'd0);
        full    = (count_q == FULL_CNT);
        pop     = (count_q != '0) && out_ready;
        // A pop in the same cycle frees the slot the new record lands in.
        push    = capture && (!full || pop);
        drop    = capture && full && !pop;

        wr_rec = '{pc: debug_wb_pc, we: debug_wb_rf_we, wnum: debug_wb_rf_wnum,
                   wdata: debug_wb_rf_wdata, seq: seq_q};

        wp_d    = push ? wp_q + PTR_ONE : wp_q;
        rp_d    = pop  ? rp_q + PTR_ONE : rp_q;
        seq_d   = capture ? seq_q + 16'd1 : seq_q;

        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (pop && !push) count_d = count_q - CNT_ONE;

        // A drop in the clear cycle survives the clear.
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = 16'd0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_ovf)                 drop_cnt_d = 16'd1;
            else if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            seq_q      <= 16'd0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 16'd0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && push) mem_q[wp_q] <= wr_rec;
    end

    always_comb begin
        head       = mem_q[rp_q];
        out_valid  = (count_q != '0);
        out_pc     = out_valid ? head.pc    : 32'd0;
        out_we     = out_valid ? head.we    : 4'd0;
        out_wnum   = out_valid ? head.wnum  : 5'd0;
        out_wdata  = out_valid ? head.wdata : 32'd0;
        out_seq    = out_valid ? head.seq   : 16'd0;
        count      = count_q;
        overflow   = overflow_q;
        drop_count = drop_cnt_q;
    end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo with DEPTH=16.
module tb_wb_trace_fifo;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [3:0]  out_we;
    logic [4:0]  out_wnum;
    logic [31:0] out_wdata;
    logic [15:0] out_seq;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_count;
    logic        clear_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    wb_trace_fifo #(.DEPTH(16)) dut (
        .clk(clk), .resetn(resetn),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_we(out_we), .out_wnum(out_wnum),
        .out_wdata(out_wdata), .out_seq(out_seq),
        .count(count), .overflow(overflow), .drop_count(drop_count),
        .clear_ovf(clear_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [3:0] we,
                         input logic [4:0] wnum, input logic [31:0] wdata);
        debug_wb_pc       = pc;
        debug_wb_rf_we    = we;
        debug_wb_rf_wnum  = wnum;
        debug_wb_rf_wdata = wdata;
    endtask

    task automatic idle();
        drive(32'd0, 4'd0, 5'd0, 32'd0);
    endtask

    initial begin
        logic [15:0] exp_seq;
        int          gaps;
        int          wrapped;

        resetn = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
        idle();
        step(); step();
        check("rst_count", count, 0);
        check("rst_valid", out_valid, 0);
        check("rst_pc", out_pc, 0);
        check("rst_seq", out_seq, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drop", drop_count, 0);

        // First capture and fall-through
        resetn = 1'b1;
        drive(32'h1c000000, 4'hF, 5'd5, 32'h12345678);
        step();
        idle();
        check("first_valid", out_valid, 1);
        check("first_pc", out_pc, 64'h1c000000);
        check("first_we", out_we, 4'hF);
        check("first_wnum", out_wnum, 5);
        check("first_wdata", out_wdata, 64'h12345678);
        check("first_seq", out_seq, 0);
        check("first_count", count, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_pc", out_pc, 64'h1c000000);
            check("hold_wdata", out_wdata, 64'h12345678);
        end

        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("drain1_count", count, 0);
        check("drain1_valid", out_valid, 0);
        check("drain1_pc_zero", out_pc, 0);

        // Non-events: r0 write, then no enables
        drive(32'h100, 4'hF, 5'd0, 32'hAA);
        step();
        drive(32'h104, 4'h0, 5'd3, 32'hBB);
        step();
        idle();
        check("ign_count", count, 0);
        check("ign_valid", out_valid, 0);
        drive(32'h108, 4'h3, 5'd7, 32'hCC);
        step();
        idle();
        check("ign_seq_kept", out_seq, 1);
        check("partial_we", out_we, 4'h3);

        // Overflow: 18 captures into 16 slots
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        for (int i = 0; i < 18; i++) begin
            drive(32'h2000 + i, 4'hF, 5'd1, i);
            step();
        end
        idle();
        check("ovf_count", count, 16);
        check("ovf_flag", overflow, 1);
        check("ovf_drops", drop_count, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_seq", out_seq, i);
            check("drain_pc", out_pc, 32'h2000 + i);
            step();
        end
        out_ready = 1'b0;
        check("drain_count", count, 0);
        drive(32'h3000, 4'hF, 5'd2, 32'h1);
        step();
        check("after_drop_seq", out_seq, 18);

        // Full FIFO, simultaneous push and pop
        for (int i = 0; i < 15; i++) begin
            drive(32'h3004 + 4 * i, 4'hF, 5'd2, 32'h2 + i);
            step();
        end
        check("full_count", count, 16);
        drive(32'h4000, 4'hF, 5'd9, 32'hDEAD);
        out_ready = 1'b1;
        check("fullpop_head", out_seq, 18);
        step();
        idle();
        check("fullpop_count", count, 16);
        check("fullpop_nodrop", drop_count, 2);
        for (int i = 0; i < 16; i++) begin
            check("fullpop_seq", out_seq, 19 + i);
            step();
        end
        out_ready = 1'b0;
        check("fullpop_empty", count, 0);

        // clear_ovf alone, then together with a drop
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check("clr_ovf", overflow, 0);
        check("clr_drop", drop_count, 0);
        for (int i = 0; i < 16; i++) begin
            drive(32'h5000 + i, 4'hF, 5'd4, i);
            step();
        end
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        idle();
        check("clrdrop_ovf", overflow, 1);
        check("clrdrop_cnt", drop_count, 1);
        check("clrdrop_count", count, 16);

        // Sequence wrap under continuous drain
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        out_ready = 1'b1;
        exp_seq = 16'd0;
        gaps = 0;
        wrapped = 0;
        for (int i = 0; i < 70000; i++) begin
            drive(i, 4'hF, 5'd6, ~i);
            if (out_valid) begin
                if (out_seq !== exp_seq) gaps++;
                if (out_seq == 16'hFFFF) wrapped = 1;
                exp_seq = exp_seq + 16'd1;
            end
            step();
        end
        check("wrap_gaps", gaps, 0);
        check("wrap_seen", wrapped, 1);
        check("wrap_count", count, 1);
        check("wrap_drops", drop_count, 0);

        // Reset mid-stream
        resetn = 1'b0;
        step();
        check("midrst_count", count, 0);
        check("midrst_valid", out_valid, 0);
        resetn = 1'b1;
        out_ready = 1'b0;
        drive(32'h6000, 4'hF, 5'd8, 32'h77);
        step();
        idle();
        check("midrst_seq", out_seq, 0);
        check("midrst_pc", out_pc, 32'h6000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_trace_fifo.md
# wb_trace_fifo

Commit-trace buffer that sits directly downstream of the CPU top's writeback debug port (`debug_wb_pc` / `debug_wb_rf_we` / `debug_wb_rf_wnum` / `debug_wb_rf_wdata`). It captures every architectural register write and tags it with a sequence number. Records are held in a FIFO and drained by a valid/ready consumer such as a trace comparator, UART dumper or logic analyser. Loss is never silent: overflow is flagged and dropped records are counted.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, 4..256.
- `AW`, log2(DEPTH): pointer width.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `debug_wb_pc` in 32: PC of the instruction in WB this cycle.
- `debug_wb_rf_we` in 4: byte write enables from WB.
- `debug_wb_rf_wnum` in 5: destination register.
- `debug_wb_rf_wdata` in 32: write data.
- `out_valid` out 1: head record available.
- `out_ready` in 1: consumer accepts head record.
- `out_pc` out 32: head record PC.
- `out_we` out 4: head record write enables.
- `out_wnum` out 5: head record register number.
- `out_wdata` out 32: head record write data.
- `out_seq` out 16: head record sequence number.
- `count` out AW+1: entries currently stored, 0..DEPTH.
- `overflow` out 1: sticky, set when at least one record was dropped.
- `drop_count` out 16: dropped records, saturating.
- `clear_ovf` in 1: synchronous clear of `overflow` and `drop_count`.

## Operation
- Capture event in a cycle: `debug_wb_rf_we != 4'b0` AND `debug_wb_rf_wnum != 5'd0`. Writes to r0 and cycles with no enables are ignored.
- Record = {pc, we, wnum, wdata, seq}, 89 bits, stored in a register array indexed by write pointer `wp`.
- `seq_ctr` (16 bit) increments by 1 on every capture event, including dropped ones, and wraps 0xFFFF→0x0000. A stored record carries the pre-increment value, so the first record after reset has seq 0. The consumer detects loss as a seq gap.
- Pop occurs when `out_valid && out_ready`; read pointer `rp` advances.
- Push occurs on a capture event when `count < DEPTH`, or when `count == DEPTH` and a pop occurs in the same cycle. The freed slot is reused, count stays DEPTH, and nothing is dropped.
- Drop occurs on a capture event when `count == DEPTH` and there is no pop. The record is discarded, `overflow` is set to 1, and `drop_count` increments, saturating at 0xFFFF.
- `wp` and `rp` are AW bits and wrap modulo DEPTH. `count` is tracked explicitly: +1 on push only, −1 on pop only, unchanged on both or neither.
- `out_valid = (count != 0)`. The `out_*` data fields are combinational from `mem[rp]` and are forced to 0 when `out_valid == 0`.
- `clear_ovf`: next cycle `overflow = 0` and `drop_count = 0`. If a drop happens in the same cycle, the drop wins: `overflow = 1`, `drop_count = 1`.
- Pop with `count == 0` is impossible (`out_valid` is 0), so `out_ready` is ignored.

## Timing
- Reset values, with `resetn` low at an edge: `wp = rp = 0`, `count = 0`, `seq_ctr = 0`, `overflow = 0`, `drop_count = 0`; hence `out_valid = 0` and all `out_*` data = 0. Memory contents are not reset.
- Reset mid-operation discards all stored records and restarts seq at 0. Capture events in a reset cycle are ignored.
- Latency: capture at edge N with the FIFO empty gives `out_valid = 1` with that record during cycle N+1 (one-cycle fall-through via storage).
- Throughput: one push and one pop per cycle sustained. A full FIFO with `out_ready` held high never drops.
- `out_*` fields are stable while `out_valid && !out_ready`, because the head only changes on a pop.
- `count`, `overflow` and `drop_count` are registered and update at the edge following the event.

## Test plan
- Reset, then capture pc=0x1c000000, we=0xF, wnum=5, wdata=0x12345678, with `out_ready` = 0 → next cycle `out_valid` = 1, fields match, `out_seq` = 0, `count` = 1; fields stay stable for 10 cycles.
- Inputs with we=0xF, wnum=0, and with we=0, wnum=3 → no push, `count` and `seq_ctr` unchanged, `out_valid` = 0.
- DEPTH=16, `out_ready` = 0, 18 capture events → `count` = 16, `overflow` = 1, `drop_count` = 2. Then drain with `out_ready` = 1: seq 0..15 in order, `count` reaches 0, next capture gets seq 18.
- Full FIFO with capture and `out_ready` = 1 in the same cycle → `count` stays 16, no drop, the popped seq is the oldest, the new record is appended at the tail.
- `clear_ovf` alone → `overflow` = 0, `drop_count` = 0. `clear_ovf` together with a drop → `overflow` = 1, `drop_count` = 1.
- 70000 captures with continuous drain → `out_seq` wraps 0xFFFF→0x0000 without a gap. Asserting `resetn` = 0 mid-stream → `count` = 0, `out_valid` = 0, next record has seq 0.
